// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one UART transmitter among N_REQ byte requesters.
// Optional packet lock (hold grant until req_last) is enabled by defining UART_TX_ARB_PACKET_LOCK_EN.
module uart_tx_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]       tx_data,
  output logic                    tx_start,
  input  logic                    tx_busy,
  output logic [N_REQ-1:0]        grant,
  output logic                    active,
  output logic [1:0]              dbg_state
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   cur, cur_nxt;
  logic [IDX_W-1:0]   last, last_nxt;
  logic [N_REQ-1:0]   grant_nxt;
  logic [DATA_W-1:0]  tx_data_nxt;
  logic               wait_first, wait_first_nxt;
  logic [N_REQ-1:0]   elig;
  logic               any_elig;
  logic [IDX_W-1:0]   win;

`ifdef UART_TX_ARB_PACKET_LOCK_EN
  // While locked, only the owner (always the last accepted requester) is eligible.
  logic locked;

  always_ff @(posedge clk) begin
    if (rst) begin
      locked <= 1'b0;
    end else if (state == LOAD && req_valid[cur]) begin
      locked <= ~req_last[cur];
    end
  end

  assign elig = locked ? (req_valid & (N_REQ'(1) << last)) : req_valid;
`else
  logic unused_last;
  assign unused_last = ^req_last;
  assign elig = req_valid;
`endif

  // Round-robin search starting one past the last served requester.
  always_comb begin
    int               j;
    logic [IDX_W-1:0] jx;
    win      = last;
    any_elig = 1'b0;
    j        = 0;
    jx       = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = int'(last) + k;
      if (j >= N_REQ) j = j - N_REQ;
      jx = IDX_W'(j);
      if (!any_elig && elig[jx]) begin
        win      = jx;
        any_elig = 1'b1;
      end
    end
  end

  // Handshake: a byte moves on the edge where req_valid[i] and req_ready[i] are both 1;
  // req_ready is a single-cycle pulse in LOAD, suppressed while rst is asserted.
  always_comb begin
    state_nxt      = state;
    cur_nxt        = cur;
    last_nxt       = last;
    grant_nxt      = grant;
    tx_data_nxt    = tx_data;
    wait_first_nxt = wait_first;
    req_ready      = '0;
    case (state)
      IDLE: begin
        if (!tx_busy && any_elig) begin
          cur_nxt   = win;
          grant_nxt = N_REQ'(1) << win;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (req_valid[cur]) begin
          if (!rst) req_ready = grant;
          tx_data_nxt = req_data[cur*DATA_W +: DATA_W];
          last_nxt    = cur;
          state_nxt   = START;
        end else begin
          grant_nxt = '0;
          state_nxt = IDLE;
        end
      end
      START: begin
        wait_first_nxt = 1'b1;
        state_nxt      = WAIT;
      end
      WAIT: begin
        // tx_busy only rises the cycle after tx_start, so the first WAIT cycle is blind.
        if (wait_first) begin
          wait_first_nxt = 1'b0;
        end else if (!tx_busy) begin
          grant_nxt = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cur        <= '0;
      last       <= IDX_W'(N_REQ - 1);
      grant      <= '0;
      tx_data    <= '0;
      wait_first <= 1'b0;
    end else begin
      state      <= state_nxt;
      cur        <= cur_nxt;
      last       <= last_nxt;
      grant      <= grant_nxt;
      tx_data    <= tx_data_nxt;
      wait_first <= wait_first_nxt;
    end
  end

  assign tx_start  = (state == START);
  assign active    = (state != IDLE);
  assign dbg_state = state;

endmodule
